// File: rtl/reflet_timer.sv
// Byte-wide down-counting timer with five bus registers, an 8-bit prescaler and a level irq.
// Bus reads and writes return data_out registered, one cycle after the access.
`timescale 1ns/1ps
module reflet_timer #(
  parameter int addr_size = 16,
  parameter int base_addr = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [addr_size-1:0] addr,
  input  logic                 write_en,
  input  logic [7:0]           data_in,
  output logic [7:0]           data_out,
  output logic                 irq,
  output logic                 tick_out
);
  localparam logic [addr_size-1:0] BASE = addr_size'(base_addr);

  logic [7:0] cfg_q, cfg_d, presc_q, presc_d, reload_q, reload_d;
  logic [7:0] count_q, count_d, pcnt_q, pcnt_d, dout_q, dout_d;
  logic       flag_q, flag_d, irq_q, irq_d, tick_q, tick;
  logic [addr_size-1:0] off;
  logic       sel, wr, wr_cfg, wr_presc, wr_reload, wr_count, wr_sts;
  logic [7:0] rdata;

  assign off       = addr - BASE;
  assign sel       = enable && (addr >= BASE) && (off <= addr_size'(4));
  assign wr        = sel && write_en;
  assign wr_cfg    = wr && (off[2:0] == 3'd0);
  assign wr_presc  = wr && (off[2:0] == 3'd1);
  assign wr_reload = wr && (off[2:0] == 3'd2);
  assign wr_count  = wr && (off[2:0] == 3'd3);
  assign wr_sts    = wr && (off[2:0] == 3'd4);
  assign tick      = cfg_q[0] && (pcnt_q == presc_q);

  always_comb begin
    rdata = 8'h00;
    case (off[2:0])
      3'd0:    rdata = cfg_q;
      3'd1:    rdata = presc_q;
      3'd2:    rdata = reload_q;
      3'd3:    rdata = count_q;
      3'd4:    rdata = {7'd0, flag_q};
      default: rdata = 8'h00;
    endcase
  end

  always_comb begin
    cfg_d    = cfg_q;
    presc_d  = presc_q;
    reload_d = reload_q;
    count_d  = count_q;
    flag_d   = flag_q;
    pcnt_d   = (cfg_q[0] && !tick) ? pcnt_q + 8'd1 : 8'd0;
    // W1C is applied first so a same-cycle hardware set overrides it.
    if (wr_sts && data_in[0]) flag_d = 1'b0;
    // A COUNT write on a tick cycle suppresses the whole tick action.
    if (tick && !wr_count) begin
      if (count_q != 8'd0) begin
        count_d = count_q - 8'd1;
      end else begin
        flag_d = 1'b1;
        if (cfg_q[1]) count_d = reload_q;
        else          cfg_d[0] = 1'b0;
      end
    end
    if (wr_cfg)    cfg_d    = data_in;
    if (wr_presc)  presc_d  = data_in;
    if (wr_reload) reload_d = data_in;
    if (wr_count)  count_d  = data_in;
    if (wr_presc || wr_count) pcnt_d = 8'd0;
    dout_d = wr ? data_in : (sel ? rdata : 8'h00);
    irq_d  = flag_d && cfg_d[2];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cfg_q    <= 8'h00;
      presc_q  <= 8'h00;
      reload_q <= 8'hFF;
      count_q  <= 8'h00;
      flag_q   <= 1'b0;
      pcnt_q   <= 8'h00;
      dout_q   <= 8'h00;
      irq_q    <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      cfg_q    <= cfg_d;
      presc_q  <= presc_d;
      reload_q <= reload_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
      pcnt_q   <= pcnt_d;
      dout_q   <= dout_d;
      irq_q    <= irq_d;
      tick_q   <= tick;
    end
  end

  assign data_out = dout_q;
  assign irq      = irq_q;
  assign tick_out = tick_q;
endmodule
